// File: rtl/match_pkg.sv
// ---------------------------------------------------------------------------
// match_pkg
// Shared definitions for the serial sync-word detector.
//   state_t  : detector FSM states (IDLE, FILL, HUNT)
//   popcount : counts set bits in a 32-bit vector; narrower vectors are
//              zero-extended by the caller before counting
// ---------------------------------------------------------------------------
package match_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HUNT = 2'd2
   } state_t;

   // Plain ripple of zero-extended unsigned adds. The maximum result is 32,
   // so six bits can never overflow.
   function automatic logic [5:0] popcount(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         c = c + 6'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/Xnor.sv
// ---------------------------------------------------------------------------
// Xnor
// Gate-library two-input XNOR cell.
//   a, b : inputs
//   y    : 1 when a and b agree
// ---------------------------------------------------------------------------
module Xnor (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_bank.sv
// ---------------------------------------------------------------------------
// xnor_bank
// WIDTH-wide bank of Xnor cells producing a per-bit equality vector.
//   a, b : WIDTH-bit operands
//   eq   : eq[i] = 1 when a[i] == b[i]
// ---------------------------------------------------------------------------
module xnor_bank #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] eq
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      Xnor u_xnor (
         .a (a[i]),
         .b (b[i]),
         .y (eq[i])
      );
   end

endmodule

// File: rtl/serial_match_detector.sv
// ---------------------------------------------------------------------------
// serial_match_detector
// Shifts in a serial bit stream and compares the most recent WIDTH bits
// against a loaded sync word. Pulses match for one cycle whenever the number
// of agreeing bits reaches THRESH.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   bit_in       : serial data bit
//   bit_valid    : bit_in is consumed on this edge
//   pattern      : sync word, MSB is the first-received bit
//   load_pattern : latch pattern and restart the window
//   armed        : window full, comparisons are live
//   match        : one-cycle pulse, agreement >= THRESH
//   match_count  : agreeing-bit count from the last evaluation
// ---------------------------------------------------------------------------
module serial_match_detector
   import match_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int THRESH = WIDTH,
   localparam int CW     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic [WIDTH-1:0] pattern,
   input  logic             load_pattern,
   output logic             armed,
   output logic             match,
   output logic [CW-1:0]    match_count
);

   localparam logic [5:0]    THRESH_W  = 6'(THRESH);
   localparam logic [CW-1:0] LAST_FILL = CW'(WIDTH - 1);

   logic [WIDTH-1:0] pat_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    fill_q;
   state_t           state_q;

   logic [WIDTH-1:0] shift_next;
   logic [WIDTH-1:0] eq;
   logic [31:0]      eq_ext;
   logic [5:0]       pop;
   logic             hit;
   logic [CW-1:0]    count_next;

   // The window as it will look once the current bit is shifted in; the
   // comparison is made against this so the arriving bit is evaluated on
   // the same edge it is accepted. The oldest bit falls off the MSB.
   assign shift_next = (shift_q << 1) | WIDTH'(bit_in);

   xnor_bank #(
      .WIDTH (WIDTH)
   ) u_xnor_bank (
      .a  (shift_next),
      .b  (pat_q),
      .eq (eq)
   );

   // Count agreeing bits and decide whether this window qualifies.
   always_comb begin
      eq_ext                = '0;
      eq_ext[WIDTH-1:0]     = eq;
      pop                   = popcount(eq_ext);
      hit                   = (pop >= THRESH_W);
      count_next            = CW'(pop);
   end

   // armed simply reflects the registered state, so it rises on the same
   // edge that evaluates the WIDTH-th accepted bit.
   assign armed = (state_q == HUNT);

   // Detector FSM with shift register, fill counter and result registers.
   // A load always takes priority and discards any bit offered on the same
   // edge. A cycle without an accepted bit holds the window and count but
   // always drops match, which keeps it a one-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q       <= '0;
         shift_q     <= '0;
         fill_q      <= '0;
         state_q     <= IDLE;
         match       <= 1'b0;
         match_count <= '0;
      end else if (load_pattern) begin
         pat_q   <= pattern;
         shift_q <= '0;
         fill_q  <= '0;
         match   <= 1'b0;
         state_q <= FILL;
      end else begin
         case (state_q)
            FILL: begin
               if (bit_valid) begin
                  shift_q <= shift_next;
                  fill_q  <= fill_q + CW'(1);
                  if (fill_q == LAST_FILL) begin
                     state_q     <= HUNT;
                     match       <= hit;
                     match_count <= count_next;
                  end else begin
                     match <= 1'b0;
                  end
               end else begin
                  match <= 1'b0;
               end
            end
            HUNT: begin
               if (bit_valid) begin
                  shift_q     <= shift_next;
                  match       <= hit;
                  match_count <= count_next;
               end else begin
                  match <= 1'b0;
               end
            end
            default: begin
               match <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_match_detector.sv
// ---------------------------------------------------------------------------
// tb_serial_match_detector
// Directed bench for serial_match_detector. Two instances share all inputs:
// dut8 uses THRESH=8 (exact match) and dut7 uses THRESH=7 (one bit slack).
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that registers them.
// ---------------------------------------------------------------------------
module tb_serial_match_detector;

   logic       clk;
   logic       rst_n;
   logic       bit_in;
   logic       bit_valid;
   logic [7:0] pattern;
   logic       load_pattern;

   logic       armed8, match8;
   logic [3:0] count8;
   logic       armed7, match7;
   logic [3:0] count7;

   int vectors;
   int errors;

   serial_match_detector #(
      .WIDTH  (8),
      .THRESH (8)
   ) dut8 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .pattern      (pattern),
      .load_pattern (load_pattern),
      .armed        (armed8),
      .match        (match8),
      .match_count  (count8)
   );

   serial_match_detector #(
      .WIDTH  (8),
      .THRESH (7)
   ) dut7 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .pattern      (pattern),
      .load_pattern (load_pattern),
      .armed        (armed7),
      .match        (match7),
      .match_count  (count7)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply one cycle of inputs on the falling edge and return just after
   // the following rising edge, when the registered outputs are settled.
   task automatic step(input logic v, input logic b, input logic ld, input logic [7:0] p);
      @(negedge clk);
      bit_valid    = v;
      bit_in       = b;
      load_pattern = ld;
      pattern      = p;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bit_in       = 1'b0;
      bit_valid    = 1'b0;
      pattern      = 8'h00;
      load_pattern = 1'b0;
      #3;
      vectors++;
      if ({armed8, match8, count8} !== 6'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b expected 000000", {armed8, match8, count8});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle_ignores_bits();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'(i % 3 == 0), 1'b0, 8'h00);
         vectors++;
         if ({armed8, match8, count8} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL idle_bit%0d: got %b expected 000000", i, {armed8, match8, count8});
         end
      end
   endtask

   task automatic test_exact_match();
      logic [7:0] word;
      word = 8'hA5;
      step(1'b0, 1'b0, 1'b1, word);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, word[i], 1'b0, 8'h00);
         vectors++;
         if (armed8 !== (i == 0) || match8 !== (i == 0)) begin
            errors++;
            $display("[TB] FAIL exact_bit%0d: armed/match got %b%b expected %b%b",
                     7 - i, armed8, match8, (i == 0), (i == 0));
         end
      end
      vectors++;
      if (count8 !== 4'd8) begin
         errors++;
         $display("[TB] FAIL exact_count: got %0d expected 8", count8);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      vectors++;
      if (match8 !== 1'b0 || armed8 !== 1'b1 || count8 !== 4'd8) begin
         errors++;
         $display("[TB] FAIL exact_pulse_end: match=%b armed=%b count=%0d expected 0 1 8",
                  match8, armed8, count8);
      end
   endtask

   task automatic test_near_miss();
      logic [7:0] word;
      word = 8'hA4;
      step(1'b0, 1'b0, 1'b1, 8'hA5);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, word[i], 1'b0, 8'h00);
      end
      vectors++;
      if (match8 !== 1'b0 || count8 !== 4'd7) begin
         errors++;
         $display("[TB] FAIL near_miss_t8: match=%b count=%0d expected 0 7", match8, count8);
      end
      vectors++;
      if (match7 !== 1'b1 || count7 !== 4'd7 || armed7 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL near_miss_t7: match=%b count=%0d armed=%b expected 1 7 1",
                  match7, count7, armed7);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      vectors++;
      if (match7 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL near_miss_t7_pulse: got %b expected 0", match7);
      end
   endtask

   task automatic test_back_to_back();
      step(1'b0, 1'b0, 1'b1, 8'hFF);
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b1, 1'b0, 8'h00);
         vectors++;
         if (match8 !== (k >= 8) || armed8 !== (k >= 8)) begin
            errors++;
            $display("[TB] FAIL overlap_bit%0d: match/armed got %b%b expected %b%b",
                     k, match8, armed8, (k >= 8), (k >= 8));
         end
         if (k >= 8) begin
            vectors++;
            if (count8 !== 4'd8) begin
               errors++;
               $display("[TB] FAIL overlap_count%0d: got %0d expected 8", k, count8);
            end
         end
      end
   endtask

   task automatic test_load_during_fill();
      logic [7:0] word;
      word = 8'hA5;
      step(1'b0, 1'b0, 1'b1, word);
      vectors++;
      if (armed8 !== 1'b0 || match8 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reload_armed_drop: armed=%b match=%b expected 0 0", armed8, match8);
      end
      for (int i = 7; i >= 4; i--) begin
         step(1'b1, word[i], 1'b0, 8'h00);
      end
      step(1'b1, 1'b0, 1'b1, word);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, word[i], 1'b0, 8'h00);
         vectors++;
         if (armed8 !== (i == 0) || match8 !== (i == 0)) begin
            errors++;
            $display("[TB] FAIL reload_bit%0d: armed/match got %b%b expected %b%b",
                     7 - i, armed8, match8, (i == 0), (i == 0));
         end
      end
   endtask

   task automatic test_hold_and_miss();
      step(1'b0, 1'b1, 1'b0, 8'h00);
      vectors++;
      if (match8 !== 1'b0 || armed8 !== 1'b1 || count8 !== 4'd8) begin
         errors++;
         $display("[TB] FAIL hold_idle_cycle: match=%b armed=%b count=%0d expected 0 1 8",
                  match8, armed8, count8);
      end
      step(1'b1, 1'b1, 1'b0, 8'h00);
      vectors++;
      if (match8 !== 1'b0 || count8 !== 4'd2) begin
         errors++;
         $display("[TB] FAIL window_4b_count: match=%b count=%0d expected 0 2", match8, count8);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      vectors++;
      if (count8 !== 4'd2) begin
         errors++;
         $display("[TB] FAIL count_hold: got %0d expected 2", count8);
      end
   endtask

   task automatic test_reset_mid_hunt();
      logic [7:0] word;
      word = 8'hA5;
      step(1'b0, 1'b0, 1'b1, word);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, word[i], 1'b0, 8'h00);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({armed8, match8, count8} !== 6'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %b expected 000000", {armed8, match8, count8});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, word[i], 1'b0, 8'h00);
         vectors++;
         if (match8 !== 1'b0 || armed8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_bit%0d: match=%b armed=%b expected 0 0",
                     7 - i, match8, armed8);
         end
      end
      step(1'b0, 1'b0, 1'b1, word);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, word[i], 1'b0, 8'h00);
      end
      vectors++;
      if (match8 !== 1'b1 || count8 !== 4'd8) begin
         errors++;
         $display("[TB] FAIL after_reload: match=%b count=%0d expected 1 8", match8, count8);
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_idle_ignores_bits();
      test_exact_match();
      test_near_miss();
      test_back_to_back();
      test_load_during_fill();
      test_hold_and_miss();
      test_reset_mid_hunt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/serial_match_detector.md
# serial_match_detector

Sync-word detector that sits directly downstream of the `Xnor` gate cell and consumes its per-bit equality output. It shifts in a serial bit stream and compares the last `WIDTH` bits against a loaded pattern with a bank of `Xnor` cells. It counts the agreeing bits and pulses `match` when the count reaches `THRESH`. It is the first sequential consumer of the gate library and is used for frame alignment on serial links.

## Interface
- `WIDTH`, 8, pattern/window length in bits (2..32)
- `THRESH`, `WIDTH`, minimum agreeing bits for a match (1..`WIDTH`)
- `CW`, `$clog2(WIDTH+1)`, width of `match_count` (derived, not overridden)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `bit_in`  in  1  serial data bit
- `bit_valid`  in  1  `bit_in` is consumed on this edge
- `pattern`  in  `WIDTH`  sync word; MSB is the first-received bit
- `load_pattern`  in  1  latch `pattern` and restart the window
- `armed`  out  1  window full; comparisons are live
- `match`  out  1  one-cycle pulse: window agreement ≥ `THRESH`
- `match_count`  out  `CW`  agreeing-bit count from the last evaluation

## Operation
- Registers: `pat_q[WIDTH]`, `shift_q[WIDTH]`, `fill_q[CW]`, `state_q`, `match`, `match_count`.
- Shift rule: on an accepted bit, `shift_q <= {shift_q[WIDTH-2:0], bit_in}`. The oldest bit sits at the MSB.
- Comparison: `eq = ~(shift_next ^ pat_q)` via the `Xnor` bank, where `shift_next` is the shift value including the current bit. `match_count` is the popcount of `eq`, using zero-extended unsigned adds with no overflow (max `WIDTH` fits `CW`).
- FSM states:
  - IDLE: reset state, no pattern loaded. Bits are ignored and `armed`=0.
  - FILL: accepts bits and increments `fill_q`. When the bit that makes `fill_q` reach `WIDTH` is accepted, go to HUNT; that same bit is evaluated.
  - HUNT: `armed`=1. Every accepted bit is evaluated. Matches may overlap; there is no lockout.
- Transitions:
  - `load_pattern`=1 in any state: `pat_q <= pattern`, `fill_q <= 0`, `shift_q <= 0`, `match <= 0`, go to FILL.
- Simultaneous events:
  - `load_pattern` and `bit_valid` on the same cycle: load wins and the bit is discarded.
  - `bit_valid`=0: the bit is not accepted. `shift_q`, `fill_q` and `match_count` hold, and `match` drops to 0.
- Reset mid-operation: all state clears immediately. The pattern is lost, so a new `load_pattern` is needed.

## Timing
- Reset values: `armed`=0, `match`=0, `match_count`=0, `pat_q`=0, `shift_q`=0, `fill_q`=0, state IDLE.
- Latency: `match` and `match_count` are registered and appear one cycle after the evaluating `bit_valid` edge.
- `match` is high for exactly one cycle per qualifying accepted bit. Back-to-back valid bits can give consecutive pulses.
- `armed` is registered from state and rises the cycle after the `WIDTH`-th accepted bit. This is the same cycle as that bit's `match`.
- `pattern` is sampled only on `load_pattern`; changes at other times have no effect.
- Combinational path from `shift_q` through the `Xnor` bank and popcount to a register is the critical path; no pipelining.

## Structure
- Shared package `match_pkg`: state enum `{IDLE, FILL, HUNT}` and a `popcount` function.
- One natural sub-module, `xnor_bank`: a parameterised `WIDTH`-wide generate of existing `Xnor` instances, output `eq[WIDTH-1:0]`.
- FSM, shift register, counter and popcount stay in `serial_match_detector`.

## Test plan
- Reset, then 20 valid bits with no load: state stays IDLE, `armed`=0, `match`=0, `match_count`=0 throughout.
- `WIDTH`=8, `THRESH`=8, load 8'hA5, stream 1,0,1,0,0,1,0,1 on consecutive cycles: `armed` and `match` rise one cycle after the 8th bit, `match_count`=8, and `match` lasts one cycle.
- Same setup, stream 8'hA4: no `match`, `match_count`=7. Rerun with `THRESH`=7: a single `match` pulse with `match_count`=7.
- Overlap: load 8'hFF, stream 10 ones: `match` pulses on the 8th, 9th and 10th evaluations (3 consecutive cycles).
- `load_pattern` with `bit_valid` on the 5th bit of a fill: the bit is discarded, `armed` drops, and 8 further bits are needed before any `match`.
- Assert `rst_n`=0 for one cycle mid-HUNT, between `bit_valid` edges: all outputs are 0 immediately, and later bits produce no `match` until a reload.
